sram_controller: RTL and testbench
==================================

# sram_controller

Sequencer between the MEM stage and the board's 16-bit external SRAM. It turns one 32-bit load or store, signalled by the MEM-stage read and write enables, into two timed 16-bit SRAM accesses, low half first. While the access is in flight it holds `ready` low, and the pipeline freeze logic uses that to stall every stage. It replaces the single-cycle data memory in the MEM stage.

## Interface
- `ADDR_BASE`, 1024: byte address that maps to SRAM word 0.
- `WAIT_CYCLES`, 2: cycles each 16-bit half-access is held on the SRAM pins (≥1).
- `clk` input 1: system clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `wr_en` input 1: store request from MEM stage (MEM_W_EN).
- `rd_en` input 1: load request from MEM stage (MEM_R_EN).
- `address` input 32: byte address (ALU result).
- `write_data` input 32: store data (Val_Rm).
- `read_data` output 32: assembled load data.
- `ready` output 1: combinational; low means freeze the pipeline.
- `SRAM_DQ` inout 16: SRAM data bus. Driven only during write phases, otherwise high-Z.
- `SRAM_ADDR` output 18: SRAM half-word address.
- `SRAM_WE_N` output 1: active-low write enable.
- `SRAM_UB_N`, `SRAM_LB_N`, `SRAM_CE_N`, `SRAM_OE_N` output 1 each: tied 0.

## Operation
- Word index: `wa = (address - ADDR_BASE) >> 2`, a 32-bit subtract. `wa[16:0]` is used, so out-of-range addresses wrap modulo 2^17 words.
- Half addresses: low half at `{wa[16:0],1'b0}`, high half at `{wa[16:0],1'b1}`.
- Write data: low half is `write_data[15:0]`, high half is `write_data[31:16]`.
- FSM states and transitions:
  - IDLE → LOW when `wr_en|rd_en`.
  - LOW → HIGH after WAIT_CYCLES cycles.
  - HIGH → DONE after WAIT_CYCLES cycles.
  - DONE → IDLE unconditionally.
- On leaving IDLE, the block latches the operation, word index and write data. Inputs that change or drop afterwards do not affect the access in flight.
- If `wr_en` and `rd_en` are both high, the write wins.
- Phase counter: reset to 0 on entering LOW and HIGH. It increments each cycle, and the phase ends when the counter equals WAIT_CYCLES-1.
- Write phases: `SRAM_WE_N`=0 for every cycle of LOW and HIGH, with `SRAM_DQ` driving the latched half.
- Read phases: `SRAM_WE_N`=1 and `SRAM_DQ` high-Z. `SRAM_DQ` is sampled into `read_data[15:0]` on the last LOW cycle and into `read_data[31:16]` on the last HIGH cycle.
- `read_data` holds its value until the next load overwrites it. Stores do not modify it.
- `ready = ~(wr_en|rd_en) | (state==DONE)`.
- `SRAM_ADDR` is 0 in IDLE and DONE.
- Reset values:
  - state IDLE, counter 0, `read_data` 0.
  - `SRAM_WE_N`=1, `SRAM_ADDR`=0, `SRAM_DQ` high-Z.
  - `ready` follows its equation.
- Reset mid-access: the access is aborted on the reset edge, and reset values apply the next cycle. A partial write may remain in the SRAM.

## Timing
- A request first visible in cycle 0 (state IDLE) gets:
  - LOW in cycles 1..W;
  - HIGH in cycles W+1..2W;
  - DONE and `ready`=1 in cycle 2W+1.
- With W=2, `ready` goes high in cycle 5, so the stall is 5 cycles.
- `ready` is low in cycle 0 itself, so the requesting instruction does not advance.
- Load data is valid in `read_data` from DONE onward.
- Back-to-back: if a new request is present in the cycle after DONE (IDLE), LOW starts the following cycle. There is no dead cycle beyond IDLE.
- No request in IDLE means `ready`=1 and no SRAM activity.

## Structure
- Shared package `mem_pkg` holds:
  - the FSM state encoding (IDLE, LOW, HIGH, DONE);
  - `SRAM_ADDR_W`=18 and `SRAM_DATA_W`=16;
  - the default `ADDR_BASE`.
- Sub-module `sram_wait_counter` (width from WAIT_CYCLES) has inputs `clr` and `en` and output `last`.
- The FSM, latches and pin drivers stay in `sram_controller`.

## Test plan
- Reset: assert `rst` for 2 cycles → `ready`=1, `SRAM_WE_N`=1, `SRAM_ADDR`=0, `SRAM_DQ`=Z, `read_data`=0.
- Store `0xDEADBEEF` to address 1024 with W=2:
  - cycles 1-2: `SRAM_ADDR`=0, DQ=`0xBEEF`, WE_N=0;
  - cycles 3-4: `SRAM_ADDR`=1, DQ=`0xDEAD`;
  - `ready`=1 only in cycle 5.
- Load from 1024 with an SRAM model seeded by the previous store → `read_data`=`0xDEADBEEF` at DONE. The value holds through a later store.
- Address 1032 → `SRAM_ADDR` 4 then 5. Address 1020 → word index wraps to `0x1FFFF`, giving `SRAM_ADDR` `0x3FFFE` then `0x3FFFF`.
- `wr_en` and `rd_en` both high → a write sequence runs. Dropping the enables in cycle 2 still completes the access, with DONE in cycle 5.
- `rst` asserted in cycle 3 of a store → next cycle is IDLE with WE_N=1 and DQ=Z. A fresh load then completes in 5 cycles.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage SRAM sequencer: FSM encoding, pin widths, default base.
// No logic; latency n/a.
// Backpressure n/a.
package mem_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;
    localparam logic [31:0] DEFAULT_ADDR_BASE = 32'd1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } sram_state_t;

endpackage

// File: rtl/sram_controller_if.sv
// MEM-stage side of the SRAM sequencer: request enables, address/data and the stall signal.
// Latency set by the controller (2*WAIT_CYCLES+1 cycles per access).
// Backpressure: ready low holds the requester until the access completes.
interface sram_controller_if;

    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output wr_en, rd_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  wr_en, rd_en, address, write_data,
        output read_data, ready
    );

endinterface

// File: rtl/sram_wait_counter.sv
// Phase timer: counts cycles of one SRAM half-access and flags the final one.
// last is combinational from the count; clr/en take effect on the next edge.
// No backpressure; clr has priority over en.
module sram_wait_counter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign last = (cnt == CW'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_controller.sv
// Splits one 32-bit MEM-stage load/store into two timed 16-bit SRAM accesses, low half first.
// Latency 2*WAIT_CYCLES+1 cycles from request to DONE; ready is low (pipeline frozen) until DONE.
// Backpressure: request is latched on leaving IDLE, so later input changes do not disturb it.
module sram_controller
    import mem_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = DEFAULT_ADDR_BASE,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    sram_controller_if.slave       mem,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_OE_N
);

    sram_state_t              state;
    sram_state_t              state_nxt;
    logic                     req;
    logic                     cnt_clr;
    logic                     cnt_en;
    logic                     cnt_last;
    logic                     op_write;
    logic [SRAM_ADDR_W-2:0]   wa;
    logic [SRAM_ADDR_W-2:0]   wa_next;
    logic [31:0]              wdata;
    logic [31:0]              rdata;
    logic                     in_phase;
    logic                     dq_drive;
    logic [SRAM_DATA_W-1:0]   dq_out;

    assign req = mem.wr_en | mem.rd_en;

    // Word index wraps modulo the SRAM size for out-of-range addresses.
    assign wa_next = (SRAM_ADDR_W-1)'((mem.address - ADDR_BASE) >> 2);

    sram_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .last (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = LOW;
                    cnt_clr   = 1'b1;
                end
            end
            LOW: begin
                cnt_en = 1'b1;
                if (cnt_last) begin
                    state_nxt = HIGH;
                    cnt_clr   = 1'b1;
                end
            end
            HIGH: begin
                cnt_en = 1'b1;
                if (cnt_last) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Write wins when both enables are high.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_write <= 1'b0;
            wa       <= '0;
            wdata    <= '0;
        end else if (state == IDLE && req) begin
            op_write <= mem.wr_en;
            wa       <= wa_next;
            wdata    <= mem.write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (!op_write && cnt_last) begin
            if (state == LOW) begin
                rdata[15:0] <= SRAM_DQ;
            end else if (state == HIGH) begin
                rdata[31:16] <= SRAM_DQ;
            end
        end
    end

    assign in_phase = (state == LOW) || (state == HIGH);
    assign dq_drive = op_write && in_phase;
    assign dq_out   = (state == HIGH) ? wdata[31:16] : wdata[15:0];

    always_comb begin
        SRAM_ADDR = '0;
        if (state == LOW) begin
            SRAM_ADDR = {wa, 1'b0};
        end else if (state == HIGH) begin
            SRAM_ADDR = {wa, 1'b1};
        end
    end

    assign SRAM_DQ   = dq_drive ? dq_out : {SRAM_DATA_W{1'bz}};
    assign SRAM_WE_N = ~dq_drive;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

    assign mem.read_data = rdata;
    assign mem.ready     = ~req | (state == DONE);

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a 16-entry SRAM model that drives DQ whenever WE_N is high.
// Each access is checked cycle by cycle against hand-computed addresses, data and ready timing.
// Backpressure: the bench holds requests until ready, as the pipeline freeze would.
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        mdl_init;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic        sram_ub_n;
    logic        sram_lb_n;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic [15:0] mem_q [16];
    int          total = 0;
    int          bad   = 0;

    sram_controller_if bus ();

    sram_controller dut (
        .clk       (clk),
        .rst       (rst),
        .mem       (bus),
        .SRAM_DQ   (sram_dq),
        .SRAM_ADDR (sram_addr),
        .SRAM_WE_N (sram_we_n),
        .SRAM_UB_N (sram_ub_n),
        .SRAM_LB_N (sram_lb_n),
        .SRAM_CE_N (sram_ce_n),
        .SRAM_OE_N (sram_oe_n)
    );

    always #5 clk = ~clk;

    // SRAM model: reads drive the bus whenever the controller is not writing.
    assign sram_dq = sram_we_n ? mem_q[sram_addr[3:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (mdl_init) begin
            for (int i = 0; i < 16; i++) mem_q[i] <= 16'hA000 | 16'(i);
        end else if (!sram_we_n) begin
            mem_q[sram_addr[3:0]] <= sram_dq;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one access starting in the current IDLE cycle; ends at the DONE cycle.
    task automatic access(input string name, input logic w, input logic r,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [17:0] lo_a, input int drop_c);
        @(negedge clk);
        bus.wr_en      = w;
        bus.rd_en      = r;
        bus.address    = a;
        bus.write_data = wd;
        #1;
        chk({name, "_c0_ready"}, 32'(bus.ready), 32'd0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == drop_c) begin
                bus.wr_en      = 1'b0;
                bus.rd_en      = 1'b0;
                bus.address    = 32'h0;
                bus.write_data = 32'h0;
            end
            #1;
            if (c < 5) begin
                chk($sformatf("%s_c%0d_addr", name, c), 32'(sram_addr),
                    32'((c <= 2) ? lo_a : (lo_a | 18'd1)));
                chk($sformatf("%s_c%0d_we_n", name, c), 32'(sram_we_n), 32'(!w));
                if (w) begin
                    chk($sformatf("%s_c%0d_dq", name, c), 32'(sram_dq),
                        32'((c <= 2) ? wd[15:0] : wd[31:16]));
                end
                chk($sformatf("%s_c%0d_ready", name, c), 32'(bus.ready),
                    32'((bus.wr_en | bus.rd_en) ? 1'b0 : 1'b1));
            end else begin
                chk({name, "_done_ready"}, 32'(bus.ready), 32'd1);
                chk({name, "_done_addr"}, 32'(sram_addr), 32'd0);
                chk({name, "_done_we_n"}, 32'(sram_we_n), 32'd1);
            end
        end
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        mdl_init       = 1'b1;
        bus.wr_en      = 1'b0;
        bus.rd_en      = 1'b0;
        bus.address    = 32'h0;
        bus.write_data = 32'h0;
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        mdl_init = 1'b0;
        #1;
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_dq_released", 32'(sram_dq), 32'h0000A000);
        chk("rst_read_data", bus.read_data, 32'h0);
        chk("tied_pins", 32'({sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n}), 32'd0);

        access("st1024", 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 18'd0, 0);
        access("ld1024", 1'b0, 1'b1, 32'd1024, 32'h0, 18'd0, 0);
        chk("ld1024_data", bus.read_data, 32'hDEADBEEF);

        access("st1032", 1'b1, 1'b0, 32'd1032, 32'h12345678, 18'd4, 0);
        chk("hold_after_store", bus.read_data, 32'hDEADBEEF);
        access("ld1032", 1'b0, 1'b1, 32'd1032, 32'h0, 18'd4, 0);
        chk("ld1032_data", bus.read_data, 32'h12345678);

        access("st1020", 1'b1, 1'b0, 32'd1020, 32'hCAFEF00D, 18'h3FFFE, 0);

        access("both_drop", 1'b1, 1'b1, 32'd1028, 32'h0BADC0DE, 18'd2, 2);
        access("ld1028", 1'b0, 1'b1, 32'd1028, 32'h0, 18'd2, 0);
        chk("ld1028_data", bus.read_data, 32'h0BADC0DE);

        // Store aborted by reset in its first HIGH cycle.
        @(negedge clk);
        bus.wr_en      = 1'b1;
        bus.address    = 32'd1036;
        bus.write_data = 32'h55554444;
        repeat (3) @(negedge clk);
        #1;
        chk("abort_c3_addr", 32'(sram_addr), 32'd7);
        rst       = 1'b1;
        bus.wr_en = 1'b0;
        @(negedge clk);
        #1;
        chk("abort_we_n", 32'(sram_we_n), 32'd1);
        chk("abort_addr", 32'(sram_addr), 32'd0);
        chk("abort_dq_released", 32'(sram_dq), 32'h0000BEEF);
        chk("abort_ready", 32'(bus.ready), 32'd1);
        chk("abort_read_data", bus.read_data, 32'h0);
        rst = 1'b0;

        access("ld1020", 1'b0, 1'b1, 32'd1020, 32'h0, 18'h3FFFE, 0);
        chk("ld1020_data", bus.read_data, 32'hCAFEF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
